// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the LSQ data-cache responder.
package dcache_pkg;

  typedef enum logic {READ = 1'b0, WRITE = 1'b1} mem_action_t;

  typedef enum logic [1:0] {IDLE, FILL_REQ, FILL_WAIT, WRITE_REQ} dcache_state_t;

  // Accesses are whole 32-bit words, so the two lowest address bits are never decoded.
  localparam int BYTE_OFF_W = 2;

  // Field widths of the default geometry: 32-bit addresses, 64 lines, 4 words per line.
  localparam int DC_OFFSET_W = BYTE_OFF_W + 2;
  localparam int DC_INDEX_W  = 6;
  localparam int DC_TAG_W    = 32 - DC_OFFSET_W - DC_INDEX_W;

  function automatic int offset_w(input int words_per_line);
    return BYTE_OFF_W + $clog2(words_per_line);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage of the direct-mapped cache.
// Reads are combinational. There is one word-write port. On refill completion a line's tag is written and its valid bit is set.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES          = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TAG_W          = DC_TAG_W,
  parameter int IDX_W          = DC_INDEX_W,
  parameter int WSEL_W         = $clog2(WORDS_PER_LINE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IDX_W-1:0]      rd_idx,
  input  logic [WSEL_W-1:0]     rd_word,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [WSEL_W-1:0]     wr_word,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  fill_done,
  input  logic [IDX_W-1:0]      fill_idx,
  input  logic [TAG_W-1:0]      fill_tag
);

  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [DATA_WIDTH-1:0] data_q [LINES*WORDS_PER_LINE];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[{rd_idx, rd_word}];

  // Valid bits are the only state cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n)
      valid_q <= '0;
    else if (fill_done)
      valid_q[fill_idx] <= 1'b1;
  end

  // Tag and data arrays are not reset.
  always_ff @(posedge clk) begin
    if (fill_done)
      tag_q[fill_idx] <= fill_tag;
    if (wr_en)
      data_q[{wr_idx, wr_word}] <= wr_data;
  end

endmodule

// File: rtl/lsq_dcache_responder.sv
// Cache-side responder for the LSQ data-cache request channel.
// It serves loads from the direct-mapped cache (write-through, no write-allocate), forwards bypass loads from the store queue, and sends committed stores to lower memory.
// Optional hit/miss/bypass counters are built when DCACHE_STATS_EN is defined.
module lsq_dcache_responder
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LINES          = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int LSQ_INDEX      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_mem_action,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [LSQ_INDEX-1:0]  req_dispatch_index,
  input  logic                  req_bypass_possible,
  input  logic [LSQ_INDEX-1:0]  req_bypass_index,
  output logic [LSQ_INDEX-1:0]  sq_read_index,
  input  logic [DATA_WIDTH-1:0] sq_read_data,
  input  logic                  flush,
  output logic                  dc_miss,
  output logic                  resp_valid,
  output logic                  resp_is_load,
  output logic [LSQ_INDEX-1:0]  resp_dispatch_index,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_bypassed,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses,
  output logic [31:0]           stat_bypasses
);

  localparam int OFF_W  = offset_w(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
  localparam int WSEL_W = $clog2(WORDS_PER_LINE);

  dcache_state_t         state;
  logic [WSEL_W-1:0]     beat_cnt;
  logic [IDX_W-1:0]      req_idx, fill_idx, arr_wr_idx;
  logic [TAG_W-1:0]      req_tag, fill_tag, rd_tag;
  logic [WSEL_W-1:0]     req_word, arr_wr_word;
  logic [DATA_WIDTH-1:0] rd_data, arr_wr_data;
  logic                  rd_valid, hit, is_write, idle_req, fill_last, arr_wr_en;
  logic [BYTE_OFF_W-1:0] unused_byte_off;

  assign req_word        = req_addr[BYTE_OFF_W +: WSEL_W];
  assign req_idx         = req_addr[OFF_W +: IDX_W];
  assign req_tag         = req_addr[ADDR_WIDTH-1 -: TAG_W];
  assign unused_byte_off = req_addr[BYTE_OFF_W-1:0];
  // The refill line is taken from the latched read address, not the live request.
  assign fill_idx        = mem_req_addr[OFF_W +: IDX_W];
  assign fill_tag        = mem_req_addr[ADDR_WIDTH-1 -: TAG_W];

  assign is_write      = (mem_action_t'(req_mem_action) == WRITE);
  assign hit           = rd_valid && (rd_tag == req_tag);
  assign idle_req      = (state == IDLE) && req_valid;
  assign fill_last     = (state == FILL_WAIT) && mem_resp_valid &&
                         (beat_cnt == WSEL_W'(WORDS_PER_LINE - 1));
  assign sq_read_index = req_bypass_index;

  dcache_array #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .DATA_WIDTH     (DATA_WIDTH),
    .TAG_W          (TAG_W),
    .IDX_W          (IDX_W),
    .WSEL_W         (WSEL_W)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (req_idx),
    .rd_word   (req_word),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .wr_en     (arr_wr_en),
    .wr_idx    (arr_wr_idx),
    .wr_word   (arr_wr_word),
    .wr_data   (arr_wr_data),
    .fill_done (fill_last),
    .fill_idx  (fill_idx),
    .fill_tag  (fill_tag)
  );

  // Steer the single word-write port: refill beats, or a store that hits a resident line.
  always_comb begin
    arr_wr_en   = 1'b0;
    arr_wr_idx  = req_idx;
    arr_wr_word = req_word;
    arr_wr_data = req_data;
    if ((state == FILL_WAIT) && mem_resp_valid) begin
      arr_wr_en   = 1'b1;
      arr_wr_idx  = fill_idx;
      arr_wr_word = beat_cnt;
      arr_wr_data = mem_resp_data;
    end else if (idle_req && is_write && hit) begin
      arr_wr_en = 1'b1;
    end
  end

  // Freeze LSQ dispatch whenever the presented request cannot complete this cycle.
  always_comb begin
    dc_miss = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE:                dc_miss = req_valid && (is_write || (!req_bypass_possible && !hit));
        FILL_REQ, FILL_WAIT: dc_miss = 1'b1;
        WRITE_REQ:           dc_miss = !mem_req_ready;
        default:             dc_miss = 1'b0;
      endcase
    end
  end

  // Control FSM with registered completion and memory-request outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= IDLE;
      beat_cnt            <= '0;
      resp_valid          <= 1'b0;
      resp_is_load        <= 1'b0;
      resp_dispatch_index <= '0;
      resp_data           <= '0;
      resp_bypassed       <= 1'b0;
      mem_req_valid       <= 1'b0;
      mem_req_write       <= 1'b0;
      mem_req_addr        <= '0;
      mem_req_wdata       <= '0;
    end else begin
      resp_valid          <= 1'b0;
      resp_is_load        <= 1'b0;
      resp_dispatch_index <= '0;
      resp_data           <= '0;
      resp_bypassed       <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (is_write) begin
              mem_req_valid <= 1'b1;
              mem_req_write <= 1'b1;
              mem_req_addr  <= {req_addr[ADDR_WIDTH-1:BYTE_OFF_W], {BYTE_OFF_W{1'b0}}};
              mem_req_wdata <= req_data;
              state         <= WRITE_REQ;
            end else if (req_bypass_possible || hit) begin
              resp_valid          <= !flush;
              resp_is_load        <= 1'b1;
              resp_dispatch_index <= req_dispatch_index;
              resp_data           <= req_bypass_possible ? sq_read_data : rd_data;
              resp_bypassed       <= req_bypass_possible;
            end else begin
              mem_req_valid <= 1'b1;
              mem_req_write <= 1'b0;
              mem_req_addr  <= {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
              mem_req_wdata <= '0;
              state         <= FILL_REQ;
            end
          end
        end
        FILL_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            beat_cnt      <= '0;
            state         <= FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          if (mem_resp_valid) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (fill_last)
              state <= IDLE;
          end
        end
        WRITE_REQ: begin
          // The store is committed; flush never cancels its completion.
          if (mem_req_ready) begin
            mem_req_valid       <= 1'b0;
            mem_req_write       <= 1'b0;
            resp_valid          <= 1'b1;
            resp_dispatch_index <= req_dispatch_index;
            state               <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  // Saturating event counters: one hit per array completion, one miss per refill, one bypass per forwarded completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_hits     <= '0;
      stat_misses   <= '0;
      stat_bypasses <= '0;
    end else if (idle_req && !is_write) begin
      if (req_bypass_possible) begin
        if (!flush) stat_bypasses <= sat_inc(stat_bypasses);
      end else if (hit) begin
        if (!flush) stat_hits <= sat_inc(stat_hits);
      end else begin
        stat_misses <= sat_inc(stat_misses);
      end
    end
  end
`else
  assign stat_hits     = '0;
  assign stat_misses   = '0;
  assign stat_bypasses = '0;
`endif

endmodule

// File: tb/tb_lsq_dcache_responder.sv
// Self-checking bench for lsq_dcache_responder.
// Its reference model is a flat backing memory plus the set of resident lines. Loads must always return the memory value, because the cache is write-through.
module tb_lsq_dcache_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_mem_action;
  logic [31:0] req_addr, req_data;
  logic [2:0]  req_dispatch_index, req_bypass_index, sq_read_index;
  logic        req_bypass_possible;
  logic [31:0] sq_read_data;
  logic        flush, dc_miss;
  logic        resp_valid, resp_is_load, resp_bypassed;
  logic [2:0]  resp_dispatch_index;
  logic [31:0] resp_data;
  logic        mem_req_valid, mem_req_ready, mem_req_write;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic [31:0] stat_hits, stat_misses, stat_bypasses;

  lsq_dcache_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .LINES(64), .WORDS_PER_LINE(4), .LSQ_INDEX(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_mem_action(req_mem_action), .req_addr(req_addr),
    .req_data(req_data), .req_dispatch_index(req_dispatch_index),
    .req_bypass_possible(req_bypass_possible), .req_bypass_index(req_bypass_index),
    .sq_read_index(sq_read_index), .sq_read_data(sq_read_data), .flush(flush),
    .dc_miss(dc_miss), .resp_valid(resp_valid), .resp_is_load(resp_is_load),
    .resp_dispatch_index(resp_dispatch_index), .resp_data(resp_data),
    .resp_bypassed(resp_bypassed), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_bypasses(stat_bypasses)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] backing [logic [31:0]];
  int          resident [int];
  int          exp_hits = 0, exp_misses = 0, exp_bypasses = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (backing.exists(w)) return backing[w];
    return w ^ 32'h5EED_0000;
  endfunction

  task automatic chk_stats(input string tag);
`ifdef DCACHE_STATS_EN
    chk({tag, "_hits"},     stat_hits,     64'(exp_hits));
    chk({tag, "_misses"},   stat_misses,   64'(exp_misses));
    chk({tag, "_bypasses"}, stat_bypasses, 64'(exp_bypasses));
`else
    chk({tag, "_hits"},     stat_hits,     64'd0);
    chk({tag, "_misses"},   stat_misses,   64'd0);
    chk({tag, "_bypasses"}, stat_bypasses, 64'd0);
`endif
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dc_miss"}, dc_miss, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_is_load"}, resp_is_load, 0);
    chk({tag, "_resp_idx"}, resp_dispatch_index, 0);
    chk({tag, "_resp_data"}, resp_data, 0);
    chk({tag, "_resp_byp"}, resp_bypassed, 0);
    chk({tag, "_mem_valid"}, mem_req_valid, 0);
    chk({tag, "_mem_write"}, mem_req_write, 0);
    chk({tag, "_mem_addr"}, mem_req_addr, 0);
    chk({tag, "_mem_wdata"}, mem_req_wdata, 0);
    chk({tag, "_sq_idx"}, sq_read_index, 0);
    chk_stats(tag);
  endtask

  // One LSQ request, held while dc_miss is high. The bench also acts as lower memory.
  // abort_beats >= 0 ends the transaction early, once that many refill beats have been delivered.
  task automatic xact(input string tag, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] didx, input bit byp,
                      input logic [2:0] bidx, input logic [31:0] sqd, input int rdy_dly,
                      input bit flush_fill, input bit flush_look, input int abort_beats);
    int          cyc, waitc, beats_left, beats_given, n_rd, n_wr, lidx, ltag;
    bit          miss_seen, done, rq_seen, exp_hit;
    logic [31:0] rq_addr, rq_wdata, beat_base, exp_data;
    cyc = 0; waitc = 0; beats_left = 0; beats_given = 0; n_rd = 0; n_wr = 0;
    miss_seen = 0; done = 0; rq_seen = 0; rq_addr = '0; rq_wdata = '0; beat_base = '0;
    lidx = int'(addr[9:4]);
    ltag = int'(addr[31:10]);
    exp_hit  = !wr && !byp && resident.exists(lidx) && resident[lidx] == ltag;
    exp_data = wr ? 32'd0 : (byp ? sqd : mem_rd(addr));

    @(negedge clk);
    req_valid = 1; req_mem_action = wr; req_addr = addr; req_data = wdata;
    req_dispatch_index = didx; req_bypass_possible = byp; req_bypass_index = bidx;
    sq_read_data = sqd;
    while (!done && !(abort_beats >= 0 && beats_given >= abort_beats) && cyc < 100) begin
      #1;
      mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0; flush = 0;
      if (mem_req_valid) begin
        if (!rq_seen) begin
          rq_seen = 1; rq_addr = mem_req_addr; rq_wdata = mem_req_wdata;
        end else begin
          chk({tag, "_req_addr_stable"}, mem_req_addr, rq_addr);
          chk({tag, "_req_wdata_stable"}, mem_req_wdata, rq_wdata);
        end
        if (waitc >= rdy_dly) begin
          mem_req_ready = 1; waitc = 0; rq_seen = 0;
          chk({tag, "_mem_write"}, mem_req_write, wr);
          if (wr) begin
            n_wr++;
            chk({tag, "_wr_addr"}, mem_req_addr, {addr[31:2], 2'b00});
            chk({tag, "_wr_data"}, mem_req_wdata, wdata);
          end else begin
            n_rd++;
            chk({tag, "_rd_addr"}, mem_req_addr, {addr[31:4], 4'h0});
            beats_left = 4; beats_given = 0; beat_base = mem_req_addr;
          end
        end else begin
          waitc++;
        end
      end else if (beats_left > 0 && $urandom_range(3) != 0) begin
        mem_resp_valid = 1;
        mem_resp_data  = mem_rd(beat_base + 32'(4 * beats_given));
        beats_given++; beats_left--;
        if (flush_fill) flush = 1;
      end
      #1;
      if (byp) chk({tag, "_sq_index"}, sq_read_index, bidx);
      if (dc_miss) miss_seen = 1; else done = 1;
      if (done && flush_look) flush = 1;
      @(negedge clk);
      cyc++;
    end
    req_valid = 0; flush = 0; mem_req_ready = 0; mem_resp_valid = 0;
    if (abort_beats >= 0 && beats_given >= abort_beats) return;
    if (!done) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end

    if (wr) begin
      chk({tag, "_miss_seen"}, miss_seen, 1);
      chk({tag, "_n_wr"}, n_wr, 1);
      chk({tag, "_n_rd"}, n_rd, 0);
      backing[{addr[31:2], 2'b00}] = wdata;
    end else if (byp) begin
      chk({tag, "_miss_seen"}, miss_seen, 0);
      chk({tag, "_mem_traffic"}, n_rd + n_wr, 0);
      if (!flush_look) exp_bypasses++;
    end else begin
      chk({tag, "_miss_seen"}, miss_seen, !exp_hit);
      chk({tag, "_n_rd"}, n_rd, exp_hit ? 0 : 1);
      chk({tag, "_n_wr"}, n_wr, 0);
      if (!exp_hit) begin
        resident[lidx] = ltag;
        exp_misses++;
      end
      if (!flush_look) exp_hits++;
    end

    chk({tag, "_resp_valid"}, resp_valid, (wr || !flush_look) ? 1 : 0);
    if (wr || !flush_look) begin
      chk({tag, "_resp_is_load"}, resp_is_load, !wr);
      chk({tag, "_resp_idx"}, resp_dispatch_index, didx);
      chk({tag, "_resp_data"}, resp_data, exp_data);
      chk({tag, "_resp_byp"}, resp_bypassed, byp);
    end
    @(negedge clk);
    chk({tag, "_resp_single"}, resp_valid, 0);
    chk_stats(tag);
  endtask

  initial begin
    rst_n = 0; req_valid = 0; req_mem_action = 0; req_addr = '0; req_data = '0;
    req_dispatch_index = '0; req_bypass_possible = 0; req_bypass_index = '0;
    sq_read_data = '0; flush = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
    backing[32'h100] = 32'hA0; backing[32'h104] = 32'hA1;
    backing[32'h108] = 32'hA2; backing[32'h10C] = 32'hA3;

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1;
    @(negedge clk);

    xact("cold_load",  0, 32'h100, 0, 3'd1, 0, 0, 0, 1, 0, 0, -1);
    xact("hit_load",   0, 32'h108, 0, 3'd2, 0, 0, 0, 0, 0, 0, -1);
    xact("store_hold", 1, 32'h104, 32'hDEAD, 3'd3, 0, 0, 0, 3, 0, 0, -1);
    xact("load_store", 0, 32'h104, 0, 3'd4, 0, 0, 0, 0, 0, 0, -1);
    xact("bypass",     0, 32'h300, 0, 3'd6, 1, 3'd5, 32'h1234, 0, 0, 0, -1);
    xact("flush_fill", 0, 32'h140, 0, 3'd2, 0, 0, 0, 0, 1, 1, -1);
    xact("after_flush", 0, 32'h14C, 0, 3'd3, 0, 0, 0, 0, 0, 0, -1);

    // Reset after two of the four refill beats; later beats must be ignored.
    xact("abort", 0, 32'h200, 0, 3'd7, 0, 0, 0, 0, 0, 0, 2);
    rst_n = 0;
    @(negedge clk);
    resident.delete();
    exp_hits = 0; exp_misses = 0; exp_bypasses = 0;
    chk_zero("mid_reset");
    rst_n = 1;
    mem_resp_valid = 1; mem_resp_data = 32'hBAD0;
    repeat (2) @(negedge clk);
    mem_resp_valid = 0;
    chk_zero("stray_beats");
    xact("reissue",  0, 32'h200, 0, 3'd7, 0, 0, 0, 0, 0, 0, -1);
    xact("old_line", 0, 32'h100, 0, 3'd1, 0, 0, 0, 0, 0, 0, -1);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      int kind;
      a = (32'($urandom_range(3)) << 10) | (32'($urandom_range(3)) << 4) |
          (32'($urandom_range(3)) << 2) | 32'($urandom_range(3));
      kind = int'($urandom_range(3));
      xact("rand", kind == 0, a, $urandom, 3'($urandom), kind == 1, 3'($urandom),
           $urandom, int'($urandom_range(2)), 0, $urandom_range(7) == 0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsq_dcache_responder.md
Name: lsq_dcache_responder

Overview:
Cache-side responder to the load/store queue's data-cache request channel. Accepts one request per cycle from the LSQ dispatch stage and serves it in one of three ways:
- loads from a direct-mapped, write-through, no-write-allocate data cache;
- loads from the store queue when the LSQ flags a bypass;
- committed stores as writes to lower memory.
Returns a completion tagged with the LSQ dispatch index, and drives dc_miss back to the hazard unit to freeze LSQ dispatch while a refill or memory write is outstanding.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, word width (word-aligned accesses only)
LINES, 64, cache lines (power of 2)
WORDS_PER_LINE, 4, words per line (power of 2)
LSQ_INDEX, 3, width of LSQ dispatch/bypass index

Ports:
clk  in  1  clock
rst_n  in  1  reset
req_valid  in  1  request present (held stable by LSQ while dc_miss=1)
req_mem_action  in  1  0=READ, 1=WRITE
req_addr  in  ADDR_WIDTH  byte address
req_data  in  DATA_WIDTH  store data
req_dispatch_index  in  LSQ_INDEX  LSQ entry of request
req_bypass_possible  in  1  load is satisfied from store queue
req_bypass_index  in  LSQ_INDEX  store-queue entry to forward
sq_read_index  out  LSQ_INDEX  = req_bypass_index (combinational)
sq_read_data  in  DATA_WIDTH  store-queue data at sq_read_index (combinational)
flush  in  1  misprediction: cancel pending load completion
dc_miss  out  1  request not completing this cycle; LSQ must hold
resp_valid  out  1  completion
resp_is_load  out  1  completion type
resp_dispatch_index  out  LSQ_INDEX  LSQ entry completed
resp_data  out  DATA_WIDTH  load data (0 for stores)
resp_bypassed  out  1  data came from store queue
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_req_write  out  1  1=word write, 0=line read
mem_req_addr  out  ADDR_WIDTH  word address (write) or line-aligned address (read)
mem_req_wdata  out  DATA_WIDTH  write data
mem_resp_valid  in  1  one refill beat, in word order
mem_resp_data  in  DATA_WIDTH  refill word
stat_hits, stat_misses, stat_bypasses  out  32 each  counters (see optional feature)

Behaviour:
Reset:
- rst_n is a synchronous, active-low reset.
- All valid bits, state and beat counter clear.
- All outputs are 0 at reset.
- Reset mid-refill abandons the refill; beats that arrive afterwards are ignored until a new refill starts.

FSM states: IDLE, FILL_REQ, FILL_WAIT, WRITE_REQ.

IDLE, req_valid=1:
- Bypass load: resp_valid next cycle, resp_data=sq_read_data (registered), resp_bypassed=1. No tag lookup, no stats hit/miss.
- Load hit (valid && tag match): resp next cycle with the array word; dc_miss=0.
- Load miss: dc_miss=1 combinationally in the same cycle; go to FILL_REQ.
- Store: dc_miss=1; if the line hits, update the cached word in this cycle; go to WRITE_REQ.

FILL_REQ:
- Drive mem_req_valid, mem_req_write=0, mem_req_addr=line base; dc_miss=1.
- On mem_req_ready, go to FILL_WAIT with beat counter=0.

FILL_WAIT:
- Each mem_resp_valid writes word[counter] and increments the counter.
- After the last beat, set valid, write the tag, return to IDLE. dc_miss stays 1 through the last-beat cycle.
- The held load then re-looks-up in IDLE and hits (miss latency = handshake + WORDS_PER_LINE + 2 cycles minimum).

WRITE_REQ:
- Drive mem_req_valid, mem_req_write=1, and the word addr/data; dc_miss=1.
- On mem_req_ready, dc_miss=0 that cycle; go to IDLE; store completion (resp_is_load=0) the next cycle.

Flush:
- Clears a load completion registered the same cycle (resp_valid forced 0 next cycle).
- In FILL_REQ/FILL_WAIT the refill still completes (line installed); the LSQ re-presents or drops the load.
- Stores are committed and are never cancelled by flush.

Other rules:
- mem_req_valid stays high until accepted; address and data are stable while it is high.
- req_valid=0 produces no response, and dc_miss=0 in IDLE.
- Index = addr[log2(WORDS_PER_LINE*4) +: log2(LINES)]; tag = remaining upper bits; byte offset bits ignored.

Optional Feature:
- Macro DCACHE_STATS_EN.
- When defined: stat_hits/stat_misses/stat_bypasses are saturating 32-bit counters, cleared by reset. A hit counts once per load completed from the array, including the post-refill lookup. A miss counts once per refill started. A bypass counts once per bypass completion.
- When undefined: the counters are absent and the stat_* outputs are tied to 0.

Decomposition:
- Package dcache_pkg: mem_action_t (READ=0, WRITE=1), dcache_state_t enum, localparams for offset/index/tag widths.
- Sub-module dcache_array: tag/valid/data storage with one read port and one word-write port, plus a line-valid write on refill completion. Reset clears valid only.

Test Plan:
- Cold load 0x100: dc_miss=1, one line read at 0x100, 4 beats 0xA0..0xA3; completion with resp_data=0xA0 and the same dispatch_index; stat_misses=1, stat_hits=1.
- Subsequent load 0x108 → resp next cycle, data 0xA2, dc_miss never asserted.
- Store 0x104=0xDEAD with the line resident → mem write 0x104/0xDEAD; hold mem_req_ready=0 for 3 cycles: dc_miss held, request stable. After acceptance, resp_is_load=0; a following load of 0x104 returns 0xDEAD.
- Load with bypass_possible=1, bypass_index=5, sq_read_data=0x1234 → sq_read_index=5, resp next cycle with data 0x1234, resp_bypassed=1, no memory traffic.
- Load miss with flush asserted in FILL_WAIT → refill finishes and the line is valid; a flush coinciding with the hit lookup produces resp_valid=0.
- Assert rst_n=0 after 2 of 4 refill beats → state IDLE, all outputs 0, the line invalid; a re-issued load misses again.
